// File: rtl/mul_accumulator.sv
// mul_accumulator: sums bursts of unsigned products (delimited by a last flag)
// and queues the finished sums in a small result FIFO with a valid/ready
// output. The upstream multiplier cannot stall, so a sum that finds the FIFO
// full is discarded and drop_o pulses for one cycle.
// Optional build macro: MUL_ACC_SAT_EN (clamp the sum at 2^WIDTHA-1 on
// overflow instead of wrapping).
module mul_accumulator #(
  parameter int WIDTHP = 8,
  parameter int WIDTHA = 16,
  parameter int CNTW   = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTHP-1:0] prod_i,
  input  logic              prod_valid_i,
  input  logic              prod_last_i,
  output logic [WIDTHA-1:0] sum_o,
  output logic [CNTW-1:0]   sum_cnt_o,
  output logic              sum_ovf_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic              drop_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTHA-1:0] acc;
  logic [CNTW-1:0]   cnt;
  logic              ovf;

  logic [WIDTHA-1:0] mem_sum [DEPTH];
  logic [CNTW-1:0]   mem_cnt [DEPTH];
  logic              mem_ovf [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic [WIDTHA:0]   raw_sum;
  logic [WIDTHA-1:0] acc_base;
  logic [WIDTHA-1:0] next_sum;
  logic [CNTW-1:0]   next_cnt;
  logic              next_ovf;
  logic              carry;
  logic              push;
  logic              pop;
  logic              full;
  logic              do_push;
  logic              drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Next burst totals: in IDLE the burst restarts from zero with count 1.
  always_comb begin
    acc_base = (state == ACCUM) ? acc : '0;
    raw_sum  = {1'b0, acc_base} + {{(WIDTHA + 1 - WIDTHP){1'b0}}, prod_i};
    carry    = raw_sum[WIDTHA];
`ifdef MUL_ACC_SAT_EN
    next_sum = carry ? {WIDTHA{1'b1}} : raw_sum[WIDTHA-1:0];
`else
    next_sum = raw_sum[WIDTHA-1:0];
`endif
    if (state == ACCUM) begin
      next_cnt = (cnt == {CNTW{1'b1}}) ? cnt : cnt + 1'b1;
      next_ovf = ovf | carry;
    end else begin
      next_cnt = CNTW'(1);
      next_ovf = carry;
    end
    push    = prod_valid_i & prod_last_i;
    pop     = sum_valid_o & sum_ready_i;
    full    = (count == CW'(DEPTH));
    do_push = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  // Burst FSM: accumulate non-last products, hand the total to the FIFO on last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (prod_valid_i) begin
      if (prod_last_i) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else begin
        state <= ACCUM;
        acc   <= next_sum;
        cnt   <= next_cnt;
        ovf   <= next_ovf;
      end
    end
  end

  // Result FIFO: circular buffer; when full, a pop frees the slot being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_sum[i] <= '0;
        mem_cnt[i] <= '0;
        mem_ovf[i] <= 1'b0;
      end
    end else begin
      drop_o <= drop;
      if (do_push) begin
        mem_sum[wr_ptr] <= next_sum;
        mem_cnt[wr_ptr] <= next_cnt;
        mem_ovf[wr_ptr] <= next_ovf;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign sum_o       = mem_sum[rd_ptr];
  assign sum_cnt_o   = mem_cnt[rd_ptr];
  assign sum_ovf_o   = mem_ovf[rd_ptr];
  assign sum_valid_o = (count != '0);

endmodule
